// File: rtl/abacus_cache_event_monitor.sv
// Cache event conditioner: registered request/hit/miss pulses, miss-to-fill
// latency measurement, outstanding-lookup tracking and protocol checking.
module abacus_cache_event_monitor #(
    parameter int LAT_W              = 16,
    parameter int MAX_OUTSTANDING    = 4,
    parameter int FILL_START_TIMEOUT = 64,
    localparam int OUT_W             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             req_valid,
    input  logic             req_ready,
    input  logic             rsp_valid,
    input  logic             rsp_hit,
    input  logic             fill_active,
    output logic             request_pulse,
    output logic             hit_pulse,
    output logic             miss_pulse,
    output logic [LAT_W-1:0] fill_latency,
    output logic             fill_latency_valid,
    output logic [LAT_W-1:0] fill_latency_max,
    output logic [OUT_W-1:0] outstanding,
    output logic             protocol_error
);

    typedef enum logic [1:0] {IDLE, FILL_WAIT, FILLING} state_e;

    state_e            state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              request_pulse_q, request_pulse_d;
    logic              hit_pulse_q, hit_pulse_d;
    logic              miss_pulse_q, miss_pulse_d;
    logic [LAT_W-1:0]  fill_latency_q, fill_latency_d;
    logic              fill_latency_valid_q, fill_latency_valid_d;
    logic [LAT_W-1:0]  fill_latency_max_q, fill_latency_max_d;
    logic [OUT_W-1:0]  outstanding_q, outstanding_d;
    logic              protocol_error_q, protocol_error_d;
    logic              accept, miss, err;

    always_comb begin
        accept  = req_valid & req_ready;
        miss    = rsp_valid & ~rsp_hit;
        cnt_inc = (cnt_q == {LAT_W{1'b1}}) ? cnt_q : cnt_q + LAT_W'(1);

        state_d              = state_q;
        cnt_d                = cnt_q;
        err                  = 1'b0;
        outstanding_d        = outstanding_q;
        fill_latency_d       = fill_latency_q;
        fill_latency_valid_d = 1'b0;
        fill_latency_max_d   = fill_latency_max_q;

        request_pulse_d = accept & enable;
        hit_pulse_d     = rsp_valid & rsp_hit & enable;
        miss_pulse_d    = miss & enable;

        // Simultaneous accept and response cancel out.
        if (accept && !rsp_valid) begin
            if (outstanding_q == OUT_W'(MAX_OUTSTANDING)) begin
                err = 1'b1;
            end else begin
                outstanding_d = outstanding_q + OUT_W'(1);
            end
        end else if (rsp_valid && !accept) begin
            if (outstanding_q == '0) begin
                err = 1'b1;
            end else begin
                outstanding_d = outstanding_q - OUT_W'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (miss && enable) begin
                    cnt_d   = LAT_W'(1);
                    state_d = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                cnt_d = cnt_inc;
                if (fill_active) begin
                    state_d = FILLING;
                end else if (32'(cnt_q) >= 32'(FILL_START_TIMEOUT)) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end
            end
            FILLING: begin
                if (fill_active) begin
                    cnt_d = cnt_inc;
                end else begin
                    fill_latency_d       = cnt_q;
                    fill_latency_valid_d = 1'b1;
                    state_d              = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A measurement completing on a clear still seeds the new maximum.
        if (clear) begin
            fill_latency_max_d = fill_latency_valid_d ? cnt_q : '0;
        end else if (fill_latency_valid_d && cnt_q > fill_latency_max_q) begin
            fill_latency_max_d = cnt_q;
        end

        protocol_error_d = err | (protocol_error_q & ~clear);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q              <= IDLE;
            cnt_q                <= '0;
            request_pulse_q      <= 1'b0;
            hit_pulse_q          <= 1'b0;
            miss_pulse_q         <= 1'b0;
            fill_latency_q       <= '0;
            fill_latency_valid_q <= 1'b0;
            fill_latency_max_q   <= '0;
            outstanding_q        <= '0;
            protocol_error_q     <= 1'b0;
        end else begin
            state_q              <= state_d;
            cnt_q                <= cnt_d;
            request_pulse_q      <= request_pulse_d;
            hit_pulse_q          <= hit_pulse_d;
            miss_pulse_q         <= miss_pulse_d;
            fill_latency_q       <= fill_latency_d;
            fill_latency_valid_q <= fill_latency_valid_d;
            fill_latency_max_q   <= fill_latency_max_d;
            outstanding_q        <= outstanding_d;
            protocol_error_q     <= protocol_error_d;
        end
    end

    assign request_pulse      = request_pulse_q;
    assign hit_pulse          = hit_pulse_q;
    assign miss_pulse         = miss_pulse_q;
    assign fill_latency       = fill_latency_q;
    assign fill_latency_valid = fill_latency_valid_q;
    assign fill_latency_max   = fill_latency_max_q;
    assign outstanding        = outstanding_q;
    assign protocol_error     = protocol_error_q;

endmodule

// File: tb/tb_abacus_cache_event_monitor.sv
// Directed bench for abacus_cache_event_monitor; fill latencies are
// checked against a queue of expected values.
module tb_abacus_cache_event_monitor;

    localparam int LAT_W = 4;
    localparam int MAXO  = 4;
    localparam int TMO   = 8;
    localparam int OUT_W = $clog2(MAXO + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             clear;
    logic             req_valid;
    logic             req_ready;
    logic             rsp_valid;
    logic             rsp_hit;
    logic             fill_active;
    logic             request_pulse;
    logic             hit_pulse;
    logic             miss_pulse;
    logic [LAT_W-1:0] fill_latency;
    logic             fill_latency_valid;
    logic [LAT_W-1:0] fill_latency_max;
    logic [OUT_W-1:0] outstanding;
    logic             protocol_error;

    int n_cmp = 0;
    int n_mis = 0;
    int exp_q[$];
    int npulse;

    abacus_cache_event_monitor #(
        .LAT_W(LAT_W),
        .MAX_OUTSTANDING(MAXO),
        .FILL_START_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .clear(clear),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_hit(rsp_hit),
        .fill_active(fill_active),
        .request_pulse(request_pulse),
        .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse),
        .fill_latency(fill_latency),
        .fill_latency_valid(fill_latency_valid),
        .fill_latency_max(fill_latency_max),
        .outstanding(outstanding),
        .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, 32'(request_pulse), 0);
        chk({tag, "_hit"}, 32'(hit_pulse), 0);
        chk({tag, "_miss"}, 32'(miss_pulse), 0);
        chk({tag, "_lat"}, 32'(fill_latency), 0);
        chk({tag, "_latv"}, 32'(fill_latency_valid), 0);
        chk({tag, "_max"}, 32'(fill_latency_max), 0);
        chk({tag, "_out"}, 32'(outstanding), 0);
        chk({tag, "_perr"}, 32'(protocol_error), 0);
    endtask

    task automatic accept_one();
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic miss_one();
        rsp_valid = 1'b1;
        rsp_hit   = 1'b0;
        tick();
        rsp_valid = 1'b0;
    endtask

    // Scoreboard: every reported latency must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && fill_latency_valid === 1'b1) begin
            if (exp_q.size() == 0)
                chk("sb_unexpected_valid", 32'(fill_latency_valid), 0);
            else
                chk("sb_latency", 32'(fill_latency), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; clear = 1'b0;
        req_valid = 1'b0; req_ready = 1'b1;
        rsp_valid = 1'b0; rsp_hit = 1'b0; fill_active = 1'b0;
        tick(); tick();
        chk_zero("in_reset");
        rst_n = 1'b1;
        tick(); tick();
        chk_zero("post_reset");

        // back-to-back accepts then a hit
        req_valid = 1'b1;
        tick();
        chk("acc0_req", 32'(request_pulse), 1);
        chk("acc0_out", 32'(outstanding), 1);
        tick();
        chk("acc1_req", 32'(request_pulse), 1);
        chk("acc1_out", 32'(outstanding), 2);
        req_valid = 1'b0;
        tick();
        chk("acc2_req", 32'(request_pulse), 0);
        chk("acc2_out", 32'(outstanding), 2);
        rsp_valid = 1'b1; rsp_hit = 1'b1;
        tick();
        rsp_valid = 1'b0;
        chk("hit_pulse", 32'(hit_pulse), 1);
        chk("hit_nomiss", 32'(miss_pulse), 0);
        chk("hit_out", 32'(outstanding), 1);
        tick();
        chk("hit_once", 32'(hit_pulse), 0);

        // latency 6: miss c0, fill c2..c5, low c6
        exp_q.push_back(6);
        miss_one();
        chk("miss_pulse", 32'(miss_pulse), 1);
        chk("miss_out", 32'(outstanding), 0);
        tick();
        fill_active = 1'b1;
        repeat (4) tick();
        fill_active = 1'b0;
        tick();
        chk("lat6_valid", 32'(fill_latency_valid), 1);
        chk("lat6_value", 32'(fill_latency), 6);
        chk("lat6_max", 32'(fill_latency_max), 6);
        tick();
        chk("lat6_valid_once", 32'(fill_latency_valid), 0);
        chk("lat6_stable", 32'(fill_latency), 6);

        // latency 3, max holds
        accept_one();
        exp_q.push_back(3);
        miss_one();
        fill_active = 1'b1;
        tick(); tick();
        fill_active = 1'b0;
        tick();
        chk("lat3_valid", 32'(fill_latency_valid), 1);
        chk("lat3_value", 32'(fill_latency), 3);
        chk("lat3_max", 32'(fill_latency_max), 6);
        chk("lat3_perr", 32'(protocol_error), 0);

        // fill-start timeout
        accept_one();
        miss_one();
        repeat (7) tick();
        chk("tmo_early", 32'(protocol_error), 0);
        tick();
        chk("tmo_perr", 32'(protocol_error), 1);
        chk("tmo_novalid", 32'(fill_latency_valid), 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_perr", 32'(protocol_error), 0);
        chk("clr_max", 32'(fill_latency_max), 0);

        // response with nothing outstanding
        rsp_valid = 1'b1; rsp_hit = 1'b1;
        tick();
        rsp_valid = 1'b0;
        chk("under_perr", 32'(protocol_error), 1);
        chk("under_out", 32'(outstanding), 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("under_clr", 32'(protocol_error), 0);

        // five accepts against a limit of four
        npulse = 0;
        req_valid = 1'b1;
        repeat (5) begin
            tick();
            npulse += int'(request_pulse);
        end
        req_valid = 1'b0;
        chk("over_pulses", 32'(npulse), 5);
        chk("over_out", 32'(outstanding), 4);
        chk("over_perr", 32'(protocol_error), 1);
        clear = 1'b1; rsp_valid = 1'b1; rsp_hit = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        rsp_valid = 1'b0;
        chk("drain_out", 32'(outstanding), 2);
        chk("drain_perr", 32'(protocol_error), 0);
        req_valid = 1'b1; rsp_valid = 1'b1;
        tick();
        req_valid = 1'b0; rsp_valid = 1'b0;
        chk("both_out", 32'(outstanding), 2);
        chk("both_perr", 32'(protocol_error), 0);
        chk("both_req", 32'(request_pulse), 1);
        rsp_valid = 1'b1;
        tick(); tick();
        rsp_valid = 1'b0;
        chk("empty_out", 32'(outstanding), 0);

        // saturation: 20-cycle fill in a 4-bit counter
        accept_one();
        exp_q.push_back(15);
        miss_one();
        fill_active = 1'b1;
        repeat (20) tick();
        fill_active = 1'b0;
        tick();
        chk("sat_valid", 32'(fill_latency_valid), 1);
        chk("sat_value", 32'(fill_latency), 15);
        chk("sat_max", 32'(fill_latency_max), 15);

        // enable drops mid-measurement: still reported
        accept_one();
        exp_q.push_back(2);
        miss_one();
        enable = 1'b0;
        fill_active = 1'b1;
        tick();
        fill_active = 1'b0;
        tick();
        chk("endrop_valid", 32'(fill_latency_valid), 1);
        chk("endrop_value", 32'(fill_latency), 2);
        chk("endrop_max", 32'(fill_latency_max), 15);

        // disabled: no pulses, no measurement, outstanding still tracks
        accept_one();
        chk("dis_req", 32'(request_pulse), 0);
        chk("dis_out1", 32'(outstanding), 1);
        miss_one();
        chk("dis_miss", 32'(miss_pulse), 0);
        chk("dis_out0", 32'(outstanding), 0);
        fill_active = 1'b1;
        repeat (3) tick();
        fill_active = 1'b0;
        tick();
        chk("dis_novalid", 32'(fill_latency_valid), 0);
        tick();
        chk("dis_novalid2", 32'(fill_latency_valid), 0);
        chk("dis_lat_hold", 32'(fill_latency), 2);

        // asynchronous reset in the middle of a fill
        enable = 1'b1;
        accept_one();
        accept_one();
        miss_one();
        fill_active = 1'b1;
        tick(); tick();
        chk("pre_rst_out", 32'(outstanding), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        fill_active = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk_zero("after_rst");
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
